// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a program image into the instruction memory from a
// byte stream (LEN_HI, LEN_LO, N x {HI, LO}, CHK) and releases the core from
// reset only after the whole image has arrived and its XOR checksum matches.
module imem_boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic              i_start,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [15:0]       o_imem_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_err
);

  // state   | meaning
  // LEN_HI  | waiting for length high byte
  // LEN_LO  | waiting for length low byte; length is validated here
  // DAT_HI  | waiting for high byte of the next word
  // DAT_LO  | waiting for low byte; the word is written the following cycle
  // CHK     | waiting for checksum byte
  // DONE    | image accepted, core released; waits for start
  // ERR     | length overflow or checksum mismatch; waits for start
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_CHK    = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  // Word counter is one bit wider than the address so that N = DEPTH fits.
  localparam int          CNT_W = ADDR_W + 1;
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t            r_state;
  logic [7:0]        r_len_hi;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_wcnt;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;

  logic              w_rx_ready;
  logic              w_xfer;
  logic [15:0]       w_len;
  logic [CNT_W-1:0]  w_wcnt_nxt;

  // Ready is a pure decode of the state: every loading state takes bytes.
  always_comb begin
    w_rx_ready = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                 (r_state == S_DAT_HI) || (r_state == S_DAT_LO) ||
                 (r_state == S_CHK);
  end

  assign w_xfer     = i_rx_valid & w_rx_ready;
  assign w_len      = {r_len_hi, i_rx_data};
  assign w_wcnt_nxt = r_wcnt + CNT_W'(1);

  // Loader FSM with registered memory-write and status outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_LEN_HI;
      r_len_hi   <= 8'h00;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_hi       <= 8'h00;
      r_chk      <= 8'h00;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 16'h0000;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len_hi <= i_rx_data;
            r_state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len <= CNT_W'(w_len);
            if (w_len == 16'h0000) begin
              r_state <= S_CHK;
            end else if (17'(w_len) > DEPTH) begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end else begin
              r_state <= S_DAT_HI;
            end
          end
        end
        S_DAT_HI: begin
          if (w_xfer) begin
            r_hi    <= i_rx_data;
            r_chk   <= r_chk ^ i_rx_data;
            r_state <= S_DAT_LO;
          end
        end
        S_DAT_LO: begin
          if (w_xfer) begin
            r_chk   <= r_chk ^ i_rx_data;
            r_we    <= 1'b1;
            r_addr  <= r_wcnt[ADDR_W-1:0];
            r_wdata <= {r_hi, i_rx_data};
            r_wcnt  <= w_wcnt_nxt;
            r_state <= (w_wcnt_nxt == r_len) ? S_CHK : S_DAT_HI;
          end
        end
        S_CHK: begin
          if (w_xfer) begin
            if (i_rx_data == r_chk) begin
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (i_start) begin
            r_addr     <= '0;
            r_wcnt     <= '0;
            r_chk      <= 8'h00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_state    <= S_LEN_HI;
          end
        end
        default: begin
          r_state <= S_LEN_HI;
        end
      endcase
    end
  end

  assign o_rx_ready   = w_rx_ready;
  assign o_imem_we    = r_we;
  assign o_imem_addr  = r_addr;
  assign o_imem_wdata = r_wdata;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: stimulus driven on the falling edge,
// outputs sampled on the falling edge, imem modelled by capturing strobes.
module tb_imem_boot_loader;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_rx_ready;
  logic        i_start;
  logic        o_imem_we;
  logic [7:0]  o_imem_addr;
  logic [15:0] o_imem_wdata;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem [256];
  int          we_cnt  = 0;
  logic        prev_we = 1'b0;
  logic        we_b2b  = 1'b0;

  imem_boot_loader #(.ADDR_W(8)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .i_start      (i_start),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_hold   (o_cpu_hold),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Instruction memory model plus strobe bookkeeping.
  always @(posedge i_clk) begin
    if (o_imem_we) begin
      mem[o_imem_addr] <= o_imem_wdata;
      we_cnt <= we_cnt + 1;
    end
    if (o_imem_we && prev_we) we_b2b <= 1'b1;
    prev_we <= o_imem_we;
  end

  // Offer one byte after 'gap' idle cycles; ok=1 if it was transferred within 'max' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, input int max, output bit ok);
    i_rx_valid = 1'b0;
    repeat (gap) @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < max; n++) begin
      if (o_rx_ready) ok = 1'b1;
      @(negedge i_clk);
      if (ok) break;
    end
    i_rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int gap_max, output bit all_ok);
    bit ok;
    all_ok = 1'b1;
    foreach (q[k]) begin
      send_byte(q[k], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, 20, ok);
      if (!ok) all_ok = 1'b0;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    tests_run++;
    if ({o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_err} !== 5'b10100) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/we/hold/done/err=%b want 10100",
               {o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_err});
    end
    tests_run++;
    if (o_imem_addr !== 8'h00 || o_imem_wdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_addr_data: got %h/%h want 00/0000", o_imem_addr, o_imem_wdata);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_basic_load();
    bit ok, all_ok;
    int we0;
    we0 = we_cnt;
    all_ok = 1'b1;
    send_byte(8'h00, 0, 20, ok); all_ok &= ok;
    send_byte(8'h02, 0, 20, ok); all_ok &= ok;
    send_byte(8'h12, 0, 20, ok); all_ok &= ok;
    send_byte(8'h34, 0, 20, ok); all_ok &= ok;
    tests_run++;
    if (o_imem_we !== 1'b1 || o_imem_addr !== 8'h00 || o_imem_wdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL basic_word0: got we=%b addr=%h data=%h want 1/00/1234",
               o_imem_we, o_imem_addr, o_imem_wdata);
    end
    send_byte(8'hAB, 0, 20, ok); all_ok &= ok;
    tests_run++;
    if (o_imem_we !== 1'b0 || o_imem_addr !== 8'h00 || o_imem_wdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL basic_hold0: got we=%b addr=%h data=%h want 0/00/1234",
               o_imem_we, o_imem_addr, o_imem_wdata);
    end
    send_byte(8'hCD, 0, 20, ok); all_ok &= ok;
    tests_run++;
    if (o_imem_we !== 1'b1 || o_imem_addr !== 8'h01 || o_imem_wdata !== 16'hABCD) begin
      tests_failed++;
      $display("FAIL basic_word1: got we=%b addr=%h data=%h want 1/01/ABCD",
               o_imem_we, o_imem_addr, o_imem_wdata);
    end
    send_byte(8'h40, 0, 20, ok); all_ok &= ok;
    tests_run++;
    if ({o_done, o_cpu_hold, o_err, o_rx_ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL basic_status: got done/hold/err/rdy=%b want 1000",
               {o_done, o_cpu_hold, o_err, o_rx_ready});
    end
    tests_run++;
    if (!all_ok || mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || (we_cnt - we0) != 2 || we_b2b) begin
      tests_failed++;
      $display("FAIL basic_mem: got ok=%0d mem0=%h mem1=%h strobes=%0d b2b=%b want 1/1234/ABCD/2/0",
               all_ok, mem[0], mem[1], we_cnt - we0, we_b2b);
    end
  endtask

  task automatic test_bad_checksum();
    bit all_ok;
    pulse_start();
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41}, 0, all_ok);
    tests_run++;
    if (!all_ok || {o_err, o_done, o_cpu_hold, o_rx_ready} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL badchk_status: got ok=%0d err/done/hold/rdy=%b want 1/1010",
               all_ok, {o_err, o_done, o_cpu_hold, o_rx_ready});
    end
    pulse_start();
    tests_run++;
    if ({o_err, o_done, o_cpu_hold, o_rx_ready} !== 4'b0011 || o_imem_addr !== 8'h00) begin
      tests_failed++;
      $display("FAIL badchk_restart: got err/done/hold/rdy=%b addr=%h want 0011/00",
               {o_err, o_done, o_cpu_hold, o_rx_ready}, o_imem_addr);
    end
  endtask

  task automatic test_empty_image();
    bit all_ok;
    int we0;
    we0 = we_cnt;
    send_seq('{8'h00, 8'h00, 8'h00}, 0, all_ok);
    tests_run++;
    if (!all_ok || {o_done, o_cpu_hold, o_err} !== 3'b100 || we_cnt != we0) begin
      tests_failed++;
      $display("FAIL empty: got ok=%0d done/hold/err=%b strobes=%0d want 1/100/0",
               all_ok, {o_done, o_cpu_hold, o_err}, we_cnt - we0);
    end
  endtask

  task automatic test_overflow();
    bit ok, all_ok;
    int we0;
    pulse_start();
    we0 = we_cnt;
    send_seq('{8'h01, 8'h01}, 0, all_ok);
    tests_run++;
    if (!all_ok || {o_err, o_done, o_cpu_hold, o_rx_ready} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL ovf_status: got ok=%0d err/done/hold/rdy=%b want 1/1010",
               all_ok, {o_err, o_done, o_cpu_hold, o_rx_ready});
    end
    send_byte(8'h12, 0, 5, ok);
    tests_run++;
    if (ok || we_cnt != we0) begin
      tests_failed++;
      $display("FAIL ovf_blocked: got accepted=%0d strobes=%0d want 0/0", ok, we_cnt - we0);
    end
  endtask

  task automatic test_gaps_and_reset();
    bit all_ok;
    int we0;
    pulse_start();
    mem[0] = 16'h0000;
    mem[1] = 16'h0000;
    we0 = we_cnt;
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40}, 3, all_ok);
    tests_run++;
    if (!all_ok || mem[0] !== 16'h1234 || mem[1] !== 16'hABCD || (we_cnt - we0) != 2 || o_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL gaps_load: got ok=%0d mem0=%h mem1=%h strobes=%0d done=%b want 1/1234/ABCD/2/1",
               all_ok, mem[0], mem[1], we_cnt - we0, o_done);
    end
    pulse_start();
    send_seq('{8'h00, 8'h02, 8'h12, 8'h34}, 0, all_ok);
    i_reset = 1'b0;
    #1;
    tests_run++;
    if ({o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_err} !== 5'b10100 ||
        o_imem_addr !== 8'h00 || o_imem_wdata !== 16'h0000) begin
      tests_failed++;
      $display("FAIL midreset: got rdy/we/hold/done/err=%b addr=%h data=%h want 10100/00/0000",
               {o_rx_ready, o_imem_we, o_cpu_hold, o_done, o_err}, o_imem_addr, o_imem_wdata);
    end
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    send_seq('{8'h00, 8'h01, 8'h55, 8'hAA, 8'hFF}, 0, all_ok);
    tests_run++;
    if (!all_ok || mem[0] !== 16'h55AA || {o_done, o_cpu_hold, o_err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reload: got ok=%0d mem0=%h done/hold/err=%b want 1/55AA/100",
               all_ok, mem[0], {o_done, o_cpu_hold, o_err});
    end
  endtask

  task automatic test_start_collisions();
    bit ok, all_ok;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b1;
    i_start    = 1'b1;
    @(negedge i_clk);
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    tests_run++;
    if ({o_cpu_hold, o_done, o_err, o_rx_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL start_wins: got hold/done/err/rdy=%b want 1001",
               {o_cpu_hold, o_done, o_err, o_rx_ready});
    end
    send_byte(8'h00, 0, 20, ok);
    all_ok = ok;
    pulse_start();
    send_byte(8'h01, 0, 20, ok); all_ok &= ok;
    send_byte(8'h77, 0, 20, ok); all_ok &= ok;
    send_byte(8'h88, 0, 20, ok); all_ok &= ok;
    send_byte(8'hFF, 0, 20, ok); all_ok &= ok;
    tests_run++;
    if (!all_ok || mem[0] !== 16'h7788 || {o_done, o_cpu_hold, o_err} !== 3'b100) begin
      tests_failed++;
      $display("FAIL start_ignored: got ok=%0d mem0=%h done/hold/err=%b want 1/7788/100",
               all_ok, mem[0], {o_done, o_cpu_hold, o_err});
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] q[$];
    logic [7:0] chk;
    logic [7:0] hi, lo;
    bit all_ok;
    int we0;
    pulse_start();
    we0 = we_cnt;
    chk = 8'h00;
    q = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) begin
      hi = 8'(i);
      lo = 8'(i) ^ 8'h5A;
      q.push_back(hi);
      q.push_back(lo);
      chk = chk ^ hi ^ lo;
    end
    q.push_back(chk);
    send_seq(q, 0, all_ok);
    tests_run++;
    if (!all_ok || (we_cnt - we0) != 256 || {o_done, o_err} !== 2'b10 || o_imem_addr !== 8'hFF) begin
      tests_failed++;
      $display("FAIL full_status: got ok=%0d strobes=%0d done/err=%b addr=%h want 1/256/10/FF",
               all_ok, we_cnt - we0, {o_done, o_err}, o_imem_addr);
    end
    tests_run++;
    if (mem[0] !== 16'h005A || mem[128] !== 16'h80DA || mem[255] !== 16'hFFA5) begin
      tests_failed++;
      $display("FAIL full_mem: got %h/%h/%h want 005A/80DA/FFA5", mem[0], mem[128], mem[255]);
    end
  endtask

  initial begin
    i_reset    = 1'b0;
    i_rx_data  = 8'h00;
    i_rx_valid = 1'b0;
    i_start    = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_empty_image();
    test_overflow();
    test_gaps_and_reset();
    test_start_collisions();
    test_full_depth();
    tests_run++;
    if (we_b2b !== 1'b0) begin
      tests_failed++;
      $display("FAIL strobe_width: got back-to-back strobe=%b want 0", we_b2b);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
